// File: rtl/acc_pkg.sv
// Shared constants and types for the 128-bit registered carry-select adder.
// Other files pull these in with import acc_pkg::*.
package acc_pkg;

    localparam int ACC_WIDTH   = 32'd128;
    localparam int ACC_GROUP   = 32'd8;
    localparam int ACC_NGROUPS = ACC_WIDTH / ACC_GROUP;

    typedef logic [ACC_WIDTH-1:0] acc_operand_t;
    typedef logic [ACC_WIDTH:0]   acc_result_t;

endpackage

// File: rtl/acc_csel_group.sv
// One carry-select slice: two GROUP-bit ripple adders (carry-in 0 and 1)
// followed by a mux steered by the incoming carry.
module acc_csel_group
    import acc_pkg::*;
#(
    parameter int GROUP = ACC_GROUP
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             sel,
    output logic [GROUP-1:0] sum,
    output logic             cout
);

    logic [GROUP-1:0] sum0_s;
    logic [GROUP-1:0] sum1_s;
    logic             cout0_s;
    logic             cout1_s;

    // Both speculative ripple chains, evaluated bit by bit.
    always_comb begin : ripple
        logic c0;
        logic c1;
        c0     = 1'b0;
        c1     = 1'b1;
        sum0_s = {GROUP{1'b0}};
        sum1_s = {GROUP{1'b0}};
        for (int i = 0; i < GROUP; i++) begin
            sum0_s[i] = a[i] ^ b[i] ^ c0;
            sum1_s[i] = a[i] ^ b[i] ^ c1;
            c0        = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
            c1        = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
        end
        cout0_s = c0;
        cout1_s = c1;
    end

    // Late-arriving carry only drives the select, keeping it off the ripple path.
    always_comb begin : select
        sum  = sel ? sum1_s : sum0_s;
        cout = sel ? cout1_s : cout0_s;
    end

endmodule

// File: rtl/acc128.sv
// Registered WIDTH-bit adder: data_out <= data_in1 + data_in2 + data_cin,
// built from a chain of carry-select groups; WIDTH must be a multiple of GROUP.
module acc128
    import acc_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH,
    parameter int GROUP = ACC_GROUP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             data_cin,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    output logic [WIDTH:0]   data_out
);

    localparam int NGROUPS = WIDTH / GROUP;

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] data_out_r;

    // Group 0 takes the external carry-in directly, so its select-mux output
    // equals a plain ripple add with data_cin.
    for (genvar g = 0; g < NGROUPS; g++) begin : gen_grp
        logic cin_s;
        logic cout_s;

        if (g == 0) begin : gen_first
            assign cin_s = data_cin;
        end else begin : gen_rest
            assign cin_s = gen_grp[g-1].cout_s;
        end

        acc_csel_group #(.GROUP(GROUP)) u_group (
            .a    (data_in1[g*GROUP +: GROUP]),
            .b    (data_in2[g*GROUP +: GROUP]),
            .sel  (cin_s),
            .sum  (sum_s[g*GROUP +: GROUP]),
            .cout (cout_s)
        );
    end

    assign sum_s[WIDTH] = gen_grp[NGROUPS-1].cout_s;

    // Result register: reset wins over enable; otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_r <= {(WIDTH+1){1'b0}};
        end else if (enable) begin
            data_out_r <= sum_s;
        end else begin
            data_out_r <= data_out_r;
        end
    end

    assign data_out = data_out_r;

endmodule

// File: tb/tb_acc128.sv
// Directed and random self-checking bench for acc128.
// Expected values are hand-computed constants or a behavioural sum model.
module tb_acc128;
    import acc_pkg::*;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         data_cin;
    acc_operand_t data_in1;
    acc_operand_t data_in2;
    acc_result_t  data_out;

    int tests;
    int fails;

    acc128 dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .data_cin (data_cin),
        .data_in1 (data_in1),
        .data_in2 (data_in2),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input acc_operand_t a, input acc_operand_t b, input logic c);
        data_in1 = a;
        data_in2 = b;
        data_cin = c;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        drive({4{32'hDEADBEEF}}, {4{32'h12345678}}, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            tests++;
            if (data_out !== {129{1'b0}}) begin
                fails++;
                $display("FAIL reset_hold[%0d]: got %h expected 0", i, data_out);
            end
        end
        reset  = 1'b0;
        enable = 1'b0;
        step();
        tests++;
        if (data_out !== {129{1'b0}}) begin
            fails++;
            $display("FAIL reset_release: got %h expected 0", data_out);
        end
    endtask

    task automatic test_carry();
        enable = 1'b1;
        drive(128'hAAAAAAAA, 128'h55555555, 1'b1);
        step();
        tests++;
        if (data_out !== 129'h100000000) begin
            fails++;
            $display("FAIL carry32: got %h expected 100000000", data_out);
        end
    endtask

    task automatic test_sequence();
        acc_operand_t a_v [3];
        acc_operand_t b_v [3];
        logic         c_v [3];
        acc_result_t  e_v [3];
        a_v = '{128'hAAAA, 128'hFFFF, 128'hF};
        b_v = '{128'h5555, 128'hFFFF, 128'hF};
        c_v = '{1'b1, 1'b0, 1'b1};
        e_v = '{129'h10000, 129'h1FFFE, 129'h1F};
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(a_v[i], b_v[i], c_v[i]);
            step();
            tests++;
            if (data_out !== e_v[i]) begin
                fails++;
                $display("FAIL seq[%0d]: got %h expected %h", i, data_out, e_v[i]);
            end
        end
    endtask

    task automatic test_boundaries();
        enable = 1'b1;
        drive({128{1'b1}}, {128{1'b1}}, 1'b1);
        step();
        tests++;
        if (data_out !== {129{1'b1}}) begin
            fails++;
            $display("FAIL max_sum: got %h expected all ones", data_out);
        end
        drive({128{1'b1}}, {128{1'b0}}, 1'b1);
        step();
        tests++;
        if (data_out !== {1'b1, {128{1'b0}}}) begin
            fails++;
            $display("FAIL full_carry: got %h expected bit128 only", data_out);
        end
        drive({128{1'b0}}, {128{1'b0}}, 1'b0);
        step();
        tests++;
        if (data_out !== {129{1'b0}}) begin
            fails++;
            $display("FAIL zero_sum: got %h expected 0", data_out);
        end
    endtask

    task automatic test_hold();
        enable = 1'b1;
        drive(128'hF, 128'hF, 1'b1);
        step();
        tests++;
        if (data_out !== 129'h1F) begin
            fails++;
            $display("FAIL hold_load: got %h expected 1F", data_out);
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) drive({128{1'bx}}, {128{1'bx}}, 1'bx);
            else        drive({4{$urandom}}, {4{$urandom}}, 1'b1);
            step();
            tests++;
            if (data_out !== 129'h1F) begin
                fails++;
                $display("FAIL hold[%0d]: got %h expected 1F", i, data_out);
            end
        end
        drive(128'h100, 128'h23, 1'b0);
        enable = 1'b1;
        step();
        tests++;
        if (data_out !== 129'h123) begin
            fails++;
            $display("FAIL hold_resume: got %h expected 123", data_out);
        end
    endtask

    task automatic test_reset_mid();
        enable = 1'b1;
        drive(128'h1000, 128'h0234, 1'b1);
        step();
        tests++;
        if (data_out !== 129'h1235) begin
            fails++;
            $display("FAIL mid_pre: got %h expected 1235", data_out);
        end
        reset = 1'b1;
        step();
        tests++;
        if (data_out !== {129{1'b0}}) begin
            fails++;
            $display("FAIL mid_reset: got %h expected 0", data_out);
        end
        reset = 1'b0;
        drive(128'h7, 128'h8, 1'b0);
        step();
        tests++;
        if (data_out !== 129'hF) begin
            fails++;
            $display("FAIL mid_after: got %h expected F", data_out);
        end
    endtask

    task automatic test_random();
        acc_result_t model_r;
        model_r = data_out === 129'hF ? 129'hF : {129{1'b0}};
        for (int i = 0; i < 10000; i++) begin
            drive({$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
            if ((i % 7) == 3) drive(data_in1 | {128{1'b1}}, data_in2, data_cin);
            enable = ($urandom_range(3, 0) != 0);
            reset  = ($urandom_range(15, 0) == 0);
            if (reset)       model_r = {129{1'b0}};
            else if (enable) model_r = {1'b0, data_in1} + {1'b0, data_in2} + {128'd0, data_cin};
            else             model_r = model_r;
            step();
            tests++;
            if (data_out !== model_r) begin
                fails++;
                $display("FAIL random[%0d]: got %h expected %h", i, data_out, model_r);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        reset    = 1'b1;
        enable   = 1'b0;
        drive({128{1'b0}}, {128{1'b0}}, 1'b0);
        test_reset();
        test_carry();
        test_sequence();
        test_boundaries();
        test_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/acc128.md
Name: acc128

Overview:
- Registered wide adder: computes data_in1 + data_in2 + data_cin and captures the full-width sum, including carry-out, in an output register.
- Used as the arithmetic datapath leaf in the computer-arithmetic block set; drives a 129-bit result to downstream logic.
- Combinational core is a carry-select adder built from fixed-width groups, so the critical path is one group ripple plus a mux chain rather than a 128-bit ripple.

Parameters:
- WIDTH, 128, operand width in bits; data_out is WIDTH+1 bits.
- GROUP, 8, carry-select group width in bits; WIDTH must be a multiple of GROUP.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  load enable for the result register.
- data_cin  input  1  carry-in to bit 0.
- data_in1  input  WIDTH  operand A, unsigned.
- data_in2  input  WIDTH  operand B, unsigned.
- data_out  output  WIDTH+1  registered sum; bit WIDTH is the carry-out.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset.
- Sum: S = zero-extended data_in1 + zero-extended data_in2 + data_cin, exact in WIDTH+1 bits, so it never overflows.
- Maximum S = 2^(WIDTH+1) - 1 (all ones).
- On each rising clk edge:
  - If reset = 1: data_out <= 0.
  - Else if enable = 1: data_out <= S.
  - Else: data_out holds its value.
- Reset has priority over enable.
- Reset value: data_out = 0.
- data_out is valid from the first edge at which reset is sampled high.
- Latency: 1 cycle. Inputs sampled at edge N appear on data_out after edge N and stay stable until edge N+1.
- No combinational path from inputs to data_out.
- No accumulation: the previous data_out is never fed back into the sum.
- No handshake. Any data_in or data_cin value with enable = 0, including X, must not affect data_out.
- Reset asserted mid-stream clears data_out on that edge, regardless of enable.
- Inputs in the same cycle are ignored.
- Adder structure, for WIDTH/GROUP groups:
  - Group 0 is a GROUP-bit ripple adder with carry-in data_cin.
  - Each higher group computes two sums in parallel, with carry-in 0 and carry-in 1.
  - Each higher group selects sum and carry-out using the previous group's carry-out.
  - The final group's carry-out is bit WIDTH of S.
- Result must be bit-exact to the behavioural equation for all inputs.

Decomposition:
- Package acc_pkg:
  - ACC_WIDTH = 128 and ACC_GROUP = 8 constants.
  - A typedef for the WIDTH-bit operand and the WIDTH+1-bit result.
  - A derived constant for the number of groups, WIDTH/GROUP.
- One sub-module, acc_csel_group:
  - GROUP-bit adder producing sum0/cout0 (carry-in 0) and sum1/cout1 (carry-in 1), plus a select mux.
  - Instantiated WIDTH/GROUP times via a generate loop.
- Top level acc128 holds the group chain and the output register.

Test Plan (each stimulus driven with enable = 1 and checked after the next rising edge; all values hex):
- Reset: hold reset = 1 for 2 cycles with arbitrary inputs -> data_out = 0. Release reset with enable = 0 -> data_out stays 0.
- Carry across 32 bits: in1 = AAAAAAAA, in2 = 55555555, cin = 1 -> data_out = 100000000.
- Next cycles, one per edge:
  - in1 = AAAA, in2 = 5555, cin = 1 -> 10000.
  - in1 = FFFF, in2 = FFFF, cin = 0 -> 1FFFE.
  - in1 = F, in2 = F, cin = 1 -> 1F.
- Boundaries:
  - in1 = in2 = all ones, cin = 1 -> data_out = all 129 bits set.
  - in1 = all ones, in2 = 0, cin = 1 -> data_out = 1 followed by 128 zero bits (only bit 128 set).
  - in1 = in2 = 0, cin = 0 -> 0.
- Hold: load 1F, then drop enable and drive new/X inputs for 3 cycles -> data_out stays 1F. Raise enable -> updates on the next edge.
- Reset mid-stream: with enable = 1 and nonzero inputs, assert reset for 1 cycle -> data_out = 0 that cycle. Next edge after release loads the current sum.
- Random: 10k random operand/cin/enable/reset vectors -> data_out matches the behavioural model every cycle.
